// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- transmit half of the UART, clocked by the 8x oversampled baud clock.
//
// Double-buffered transmitter: a host write lands in the transmit data register
// (TDR). When the line is free, the byte moves to the transmit shift register
// (TSR). The TSR then sends one frame: a start bit, data_bits data bits LSB
// first, an optional even-parity bit, and one stop bit. Each bit lasts 8 clocks.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : an even-parity bit follows the data bits (8E1, 11 bit times)
//   undefined : no parity state or parity register (8N1, 10 bit times)
//
// Parameters:
//   data_bits  frame data width, legal range 5..8 (default 8)
//
// Ports:
//   bclkx8   in   1          8x baud clock, the only clock
//   rst_n    in   1          synchronous active-low reset
//   tx_data  in   data_bits  byte to send, captured when tx_load is accepted
//   tx_load  in   1          write strobe, accepted only while tdre = 1
//   tdre     out  1          TDR empty, the host may write
//   tx_busy  out  1          a frame is in progress
//   txd      out  1          serial line, registered, idles high
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned data_bits = 8
) (
  input  logic                 bclkx8,
  input  logic                 rst_n,
  input  logic [data_bits-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tdre,
  output logic                 tx_busy,
  output logic                 txd
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  localparam logic [3:0] LastBit = 4'(data_bits);

  state_e               state_q, state_d;
  logic [data_bits-1:0] tdr_q, tdr_d;
  logic [data_bits-1:0] tsr_q, tsr_d;
  logic [2:0]           ct1_q, ct1_d;
  logic [3:0]           ct2_q, ct2_d;
  logic                 tdre_q, tdre_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic bit_end;
  logic transfer;

  // The last oversample clock of the current bit time.
  assign bit_end = (ct1_q == 3'd7);

  // TDR -> TSR move: from IDLE as soon as TDR is full, or straight out of the
  // final stop clock so consecutive frames abut with no idle gap. It needs
  // tdre = 0 while a host write needs tdre = 1, so the two never collide.
  assign transfer = !tdre_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    tdr_d   = tdr_q;
    tsr_d   = tsr_q;
    ct1_d   = ct1_q + 3'd1;   // wraps 7 -> 0 at the end of each bit time
    ct2_d   = ct2_q;
    tdre_d  = tdre_q;
    txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Host write into TDR.
    if (tx_load && tdre_q) begin
      tdr_d  = tx_data;
      tdre_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        ct1_d = 3'd0;
        ct2_d = 4'd0;
        txd_d = 1'b1;
      end

      START: begin
        if (bit_end) begin
          txd_d   = tsr_q[0];
          tsr_d   = {1'b0, tsr_q[data_bits-1:1]};
          ct2_d   = 4'd1;
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (ct2_q < LastBit) begin
            txd_d = tsr_q[0];
            tsr_d = {1'b0, tsr_q[data_bits-1:1]};
            ct2_d = ct2_q + 4'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = PARITY;
`else
            txd_d   = 1'b1;
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          ct2_d   = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Start a new frame: overrides the IDLE / end-of-STOP defaults above.
    if (transfer) begin
      tsr_d   = tdr_q;
      tdre_d  = 1'b1;
      ct1_d   = 3'd0;
      txd_d   = 1'b0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      // Even parity of the byte being launched, frozen for the whole frame.
      parity_d = ^tdr_q;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge bclkx8) begin
    // NOTE: non-blocking assignments here, so every register samples the
    // pre-edge value of the others regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      tdr_q   <= '0;
      tsr_q   <= '0;
      ct1_q   <= 3'd0;
      ct2_q   <= 4'd0;
      tdre_q  <= 1'b1;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tdr_q   <= tdr_d;
      tsr_q   <= tsr_d;
      ct1_q   <= ct1_d;
      ct2_q   <= ct2_d;
      tdre_q  <= tdre_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge bclkx8) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tdre    = tdre_q;
  assign tx_busy = busy_q;
  assign txd     = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- directed testbench for uart_tx (data_bits = 8).
// Follows UART_TX_PARITY_EN so the same bench covers 8N1 and 8E1 builds.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 11;   // bit times per frame
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tdre;
  logic       tx_busy;
  logic       txd;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx #(.data_bits(8)) dut (
    .bclkx8  (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .tdre    (tdre),
    .tx_busy (tx_busy),
    .txd     (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit slot j of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int j);
    if (j == 0)                return 1'b0;
    if (j <= 8)                return d[j-1];
    if (PAR && j == 9)         return ^d;
    return 1'b1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one write strobe; returns at the falling edge after the accepting edge k.
  task automatic do_load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Sample every bit of a frame mid-bit. first_wait = rising edges from the
  // current falling edge to the first (start bit) mid-bit sample.
  task automatic check_frame(input logic [7:0] d, input int first_wait, input string name);
    for (int j = 0; j < NB; j++) begin
      step(j == 0 ? first_wait : 8);
      vectors++;
      if (txd !== exp_bit(d, j)) begin
        miscompares++;
        $display("FAIL %s bit%0d: txd=%b expected=%b", name, j, txd, exp_bit(d, j));
      end
    end
  endtask

  task automatic expect_idle(input string name);
    vectors++;
    if (txd !== 1'b1 || tdre !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: txd/tdre/busy=%b%b%b expected=110", name, txd, tdre, tx_busy);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tx_load = 1'b1;
    tx_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_idle("reset_hold");
    end
    @(negedge clk);
    tx_load = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4);
      expect_idle("post_reset_idle");
    end
  endtask

  // Single frame from an idle line, including tdre/busy timing and length.
  task automatic test_frame(input logic [7:0] d, input string name);
    do_load(d);                                   // after edge k
    vectors++;
    if (tdre !== 1'b0) begin
      miscompares++;
      $display("FAIL %s tdre_after_load: tdre=%b expected=0", name, tdre);
    end
    step(1);                                      // after edge k+1
    vectors++;
    if (txd !== 1'b0 || tdre !== 1'b1 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s launch: txd/tdre/busy=%b%b%b expected=011", name, txd, tdre, tx_busy);
    end
    check_frame(d, 4, name);                      // ends after edge k+8NB-3
    step(3);                                      // after edge k+8NB: last stop clock
    vectors++;
    if (tx_busy !== 1'b1 || txd !== 1'b1) begin
      miscompares++;
      $display("FAIL %s last_stop: busy/txd=%b%b expected=11", name, tx_busy, txd);
    end
    step(1);                                      // after edge k+8NB+1
    expect_idle({name, "_end"});
  endtask

  task automatic test_back_to_back();
    do_load(8'h55);                               // after edge k
    step(1);                                      // after edge k+1
    vectors++;
    if (tdre !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b tdre_free: tdre=%b expected=1", tdre);
    end
    tx_data = 8'h0F;
    tx_load = 1'b1;
    step(1);                                      // accepted at edge k+2
    tx_load = 1'b0;
    vectors++;
    if (tdre !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b tdre_pending: tdre=%b expected=0", tdre);
    end
    check_frame(8'h55, 3, "b2b_first");
    step(4);                                      // after edge k+8NB+1: next start bit
    vectors++;
    if (txd !== 1'b0 || tx_busy !== 1'b1 || tdre !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b no_gap: txd/busy/tdre=%b%b%b expected=011", txd, tx_busy, tdre);
    end
    check_frame(8'h0F, 4, "b2b_second");
    step(4);
    expect_idle("b2b_end");
  endtask

  task automatic test_drop_while_full();
    do_load(8'h33);                               // after edge k, tdre = 0
    tx_data = 8'hFF;
    tx_load = 1'b1;
    step(1);                                      // edge k+1: write must be ignored
    tx_load = 1'b0;
    vectors++;
    if (tdre !== 1'b1) begin
      miscompares++;
      $display("FAIL drop tdre: tdre=%b expected=1", tdre);
    end
    check_frame(8'h33, 4, "drop_frame");
    step(4);
    expect_idle("drop_end");
    step(20);
    expect_idle("drop_no_second_frame");
  endtask

  task automatic test_reset_mid_frame();
    do_load(8'h00);                               // after edge k
    step(1);                                      // after edge k+1, TDR free again
    tx_data = 8'hC3;                              // pending byte that reset must discard
    tx_load = 1'b1;
    step(1);
    tx_load = 1'b0;
    step(33);                                     // after edge k+35: mid data bit 3
    vectors++;
    if (txd !== 1'b0 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid pre: txd/busy=%b%b expected=01", txd, tx_busy);
    end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    expect_idle("rst_mid_abort");
    step(30);
    expect_idle("rst_mid_pending_dropped");
    test_frame(8'h81, "after_rst");
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, "frame_A5");
    test_back_to_back();
    test_drop_while_full();
    test_reset_mid_frame();
    if (PAR) begin
      test_frame(8'h07, "par_07");
      test_frame(8'h03, "par_03");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART, running on the same 8x-oversampled baud clock as the receive path. Double-buffered: a host write lands in the transmit data register (TDR) and moves to the transmit shift register (TSR) when the line is free. The block then serialises one frame: start bit, `data_bits` data bits LSB-first, an optional even-parity bit, and one stop bit.

## Interface
- `data_bits`, default 8, frame data width; legal range 5–8.
- `bclkx8`  input  1  8x baud clock; the only clock.
- `rst_n`  input  1  synchronous, active-low reset, sampled on rising `bclkx8`.
- `tx_data`  input  `data_bits`  byte to send; sampled when `tx_load` is accepted.
- `tx_load`  input  1  write strobe; accepted only when `tdre`=1.
- `tdre`  output  1  TDR empty; the host may write.
- `tx_busy`  output  1  a frame is in progress (state ≠ IDLE).
- `txd`  output  1  serial line, registered; idles high.

## Operation
- All logic is on rising `bclkx8`. All outputs are registered.
- Storage:
  - TDR, `data_bits` wide.
  - TSR, `data_bits` wide.
  - `ct1`, 3-bit oversample counter.
  - `ct2`, 4-bit bit counter.
- Each bit time is exactly 8 cycles. `ct1` counts 0..7. The bit ends in the cycle where `ct1`=7, and `ct1` then wraps to 0.
- Host write:
  - `tx_load`=1 with `tdre`=1: TDR ← `tx_data`, and `tdre` is 0 from the next cycle.
  - `tx_load`=1 with `tdre`=0: ignored; TDR is unchanged and no flag is raised.
- States:
  - IDLE:
    - `txd`=1.
    - If `tdre`=0: TSR ← TDR, `tdre` ← 1, `ct1` ← 0, `txd` ← 0, go to START.
  - START:
    - `txd`=0 for 8 cycles.
    - At `ct1`=7: `txd` ← TSR[0], shift TSR right, `ct2` ← 1, go to DATA.
  - DATA:
    - Each bit is held 8 cycles.
    - At `ct1`=7 with `ct2`<`data_bits`: `txd` ← next LSB, shift, `ct2` ← `ct2`+1.
    - At `ct1`=7 with `ct2`=`data_bits`: go to PARITY (macro defined), driving the parity bit; otherwise go to STOP with `txd` ← 1.
  - PARITY:
    - `txd` = XOR of all sent data bits (even parity), held 8 cycles.
    - At `ct1`=7: `txd` ← 1, go to STOP.
  - STOP:
    - `txd`=1 for 8 cycles.
    - At `ct1`=7, if `tdre`=0: perform the IDLE transfer directly and go to START, with no idle cycle between frames.
    - At `ct1`=7 otherwise: go to IDLE.
- Parity is computed from TDR contents at the moment of transfer, stored in a 1-bit register.
- Write and transfer in the same cycle cannot collide: a transfer needs `tdre`=0, and a write needs `tdre`=1.
- A write accepted at any point during a frame, including the last STOP cycle, is held in TDR. It is sent as the next frame.

## Timing
- Reset (`rst_n`=0 at a rising edge), from the next cycle:
  - `txd`=1, `tdre`=1, `tx_busy`=0.
  - State IDLE; `ct1`=`ct2`=0; TDR and TSR = 0.
- Reset mid-frame aborts the frame immediately. `txd` returns high the cycle after reset, and any pending TDR data is discarded.
- Write accepted at edge k, line idle:
  - `tdre`=0 after edge k.
  - After edge k+1: `txd`=0 (start bit), `tdre`=1, `tx_busy`=1.
- Data bit i is driven from edge k+1+8(i+1) for 8 cycles.
- Frame length:
  - 8N1: 80 cycles; `tx_busy` falls after edge k+81 if no frame is pending.
  - 8E1: 88 cycles.
- Back-to-back frames: the start bit of frame n+1 immediately follows the last stop cycle of frame n.
- Maximum sustained throughput is one frame per 80 cycles (8N1), provided the host writes while `tdre`=1.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in. An even-parity bit follows the data bits, giving 8E1 with 11 bit times.
  - Undefined: no PARITY state and no parity register. DATA goes straight to STOP, giving 8N1 with 10 bit times.
  - The host interface is the same in both builds.

## Test plan
- Reset with `tx_load`=1 held throughout → `txd`=1, `tdre`=1, `tx_busy`=0, TDR unchanged; no frame starts until the first accepted load after reset is released.
- Load 0xA5 (8N1) → `txd` samples at mid-bit (`ct1`=4) read 0,1,0,1,0,0,1,0,1,1; `tdre` back to 1 one cycle after the load; `tx_busy` high for 80 cycles.
- Load 0x55, then load 0x0F as soon as `tdre`=1 → frames abut with no idle cycle; second frame reads 0,1,1,1,1,0,0,0,0,1.
- Load 0x33, then pulse `tx_load` with 0xFF while `tdre`=0 → 0xFF is dropped; exactly one frame (0x33) is sent; `tdre`=1 afterwards.
- Assert `rst_n`=0 during data bit 3 of 0x00 → `txd`=1 and `tx_busy`=0 the next cycle; a subsequent load of 0x81 produces a clean frame.
- With `UART_TX_PARITY_EN`: 0x07 → parity bit 1; 0x03 → parity bit 0; frame is 88 cycles.
